// File: rtl/ctrl_fsm_gen.sv
// Instruction-sequencing controller for the accumulator processor: Moore decode of state/wait counter.
// Optional build macro CTRL_ILLEGAL_TRAP_EN: illegal opcodes halt instead of executing as NOP.
module ctrl_fsm_gen #(
  parameter int NREG     = 6,
  parameter int MEM_WAIT = 2,
  parameter int ALU_OP_W = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [15:0]         instruction,
  input  logic                z,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [5+NREG:0]     write_en,
  output logic [2+NREG:0]     inc_en,
  output logic [4:0]          read_en,
  output logic                alu_wr,
  output logic                end_process,
  output logic                illegal
);

  localparam int WE_W = 6 + NREG;
  localparam int IE_W = 3 + NREG;
  localparam int CW   = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_WAIT - 1);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWR  = 4'd4;
  localparam logic [3:0] S_ALU1   = 4'd5;
  localparam logic [3:0] S_ALU2   = 4'd6;
  localparam logic [3:0] S_IMM    = 4'd7;
  localparam logic [3:0] S_JMPLD  = 4'd8;
  localparam logic [3:0] S_SKIP   = 4'd9;
  localparam logic [3:0] S_HALT   = 4'd10;
  localparam logic [3:0] S_EXEC   = 4'd11;
  localparam logic [3:0] S_OPND   = 4'd12;

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    op_q;
  logic [3:0]    idx_q;
  logic          z_q;
  logic          end_q;
  logic          ill_q;
  logic          unused_s;

  function automatic logic is_illegal(input logic [5:0] op, input logic [3:0] idx);
    return (op > 6'd18) ||
           (((op == 6'd3) || (op == 6'd4) || (op == 6'd13)) && ({1'b0, idx} >= 5'(NREG)));
  endfunction

  assign unused_s = ^{instruction[15:12], instruction[7:6]};

  // Next-state and wait-counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
        else       state_d = S_IDLE;
      end
      S_FETCH, S_MEMRD, S_MEMWR, S_IMM, S_JMPLD: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_JMPLD: state_d = S_FETCH;
            default: state_d = S_SKIP;
          endcase
        end else begin
          cnt_d = cnt_q + CW'(1'b1);
        end
      end
      S_DECODE: begin
        if (is_illegal(instruction[5:0], instruction[11:8])) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          state_d = S_EXEC;
`endif
        end else begin
          case (instruction[5:0])
            6'd1:                        state_d = S_MEMRD;
            6'd2:                        state_d = S_MEMWR;
            6'd7, 6'd8, 6'd9, 6'd10:     state_d = S_ALU1;
            6'd14, 6'd15, 6'd16, 6'd17:  state_d = S_OPND;
            6'd18:                       state_d = S_HALT;
            default:                     state_d = S_EXEC;
          endcase
        end
      end
      // PC has stepped over the operand word; pick the operand consumer
      S_OPND: begin
        case (op_q)
          6'd14:   state_d = S_IMM;
          6'd15:   state_d = S_JMPLD;
          6'd16:   state_d = z_q ? S_JMPLD : S_SKIP;
          6'd17:   state_d = z_q ? S_SKIP : S_JMPLD;
          default: state_d = S_SKIP;
        endcase
      end
      S_EXEC, S_ALU2, S_SKIP: state_d = S_FETCH;
      S_ALU1:                 state_d = S_ALU2;
      S_HALT:                 state_d = S_HALT;
      default:                state_d = S_IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    alu_op   = '0;
    write_en = '0;
    inc_en   = '0;
    read_en  = 5'd0;
    alu_wr   = 1'b0;
    case (state_q)
      S_FETCH: begin
        read_en     = 5'd4;
        write_en[2] = 1'b1;
      end
      S_DECODE: read_en = 5'd4;
      S_MEMRD, S_IMM: begin
        read_en     = 5'd4;
        write_en[4] = 1'b1;
      end
      S_MEMWR: begin
        read_en     = 5'd3;
        write_en[5] = 1'b1;
      end
      S_JMPLD: begin
        read_en     = 5'd4;
        write_en[1] = 1'b1;
      end
      S_ALU1: alu_op = ALU_OP_W'(op_q - 6'd6);
      S_ALU2: begin
        alu_op    = ALU_OP_W'(op_q - 6'd6);
        alu_wr    = 1'b1;
        inc_en[0] = 1'b1;
      end
      S_OPND, S_SKIP: inc_en[0] = 1'b1;
      S_EXEC: begin
        inc_en[0] = 1'b1;
        if (!is_illegal(op_q, idx_q)) begin
          case (op_q)
            6'd3: begin
              read_en  = 5'd3;
              write_en = WE_W'(1'b1) << ({1'b0, idx_q} + 5'd6);
            end
            6'd4: begin
              read_en     = 5'd8 + {1'b0, idx_q};
              write_en[4] = 1'b1;
            end
            6'd5: begin
              read_en     = 5'd3;
              write_en[3] = 1'b1;
            end
            6'd6: begin
              read_en     = 5'd2;
              write_en[4] = 1'b1;
            end
            6'd11:   inc_en[1] = 1'b1;
            6'd12:   inc_en[2] = 1'b1;
            6'd13:   inc_en = inc_en | (IE_W'(1'b1) << ({1'b0, idx_q} + 5'd3));
            default: inc_en[0] = 1'b1;
          endcase
        end else begin
          read_en = 5'd0;
        end
      end
      default: read_en = 5'd0;
    endcase
  end

  // State, operand latch and registered status flags
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 6'd0;
      idx_q   <= 4'd0;
      z_q     <= 1'b0;
      end_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_DECODE) begin
        op_q  <= instruction[5:0];
        idx_q <= instruction[11:8];
        z_q   <= z;
      end
      ill_q <= (state_q == S_DECODE) && is_illegal(instruction[5:0], instruction[11:8]);
      end_q <= (state_q == S_HALT);
    end
  end

  assign end_process = end_q;
  assign illegal     = ill_q;

endmodule

// File: doc/ctrl_fsm_gen.md
Name: ctrl_fsm_gen

Overview:
- Parametrised next-generation instruction-sequencing controller for the accumulator processor.
- Decodes a fetched 16-bit instruction and drives register write strobes, increment strobes, bus-source select and ALU opcode for the datapath.
- Generalised over general-register count and memory wait states. Adds a register-index operand field, start/end handshake and illegal-opcode detection.
- Sits between the instruction register/datapath and the top-level sequencer that issues start.

Parameters:
- NREG, 6: number of general registers R0..R(NREG-1); legal range 1..16.
- MEM_WAIT, 2: cycles each memory read or write strobe is held; legal range 1..8.
- ALU_OP_W, 3: width of alu_op.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; leaving IDLE requires start=1.
- instruction  in  16  IR contents. [5:0] opcode, [11:8] register index.
- z  in  1  ALU zero flag.
- alu_op  out  ALU_OP_W  0 pass, 1 add, 2 sub, 3 lshift, 4 rshift.
- write_en  out  6+NREG  one-hot load strobes:
  - bit 0 AR, 1 PC, 2 IR, 3 DAR, 4 AC, 5 MEM-write, 6+i Ri.
- inc_en  out  3+NREG  increment strobes:
  - bit 0 PC, 1 AC, 2 DAR, 3+i Ri.
- read_en  out  5  bus source select:
  - 0 none/ALU, 1 PC, 2 DAR, 3 AC, 4 MEM, 8+i Ri.
- alu_wr  out  1  AC and Z capture ALU result.
- end_process  out  1  registered; 1 while in HALT.
- illegal  out  1  registered one-cycle pulse on an undefined opcode.

Behaviour:
- Reset (synchronous): state=IDLE, wait counter=0, end_process=0, illegal=0. All combinational outputs are 0 in IDLE.
- Outputs are a Moore decode of state, wait counter and latched opcode/index. end_process and illegal are registered one cycle after the causing state.
- States: IDLE, FETCH, DECODE, MEMRD, MEMWR, ALU1, ALU2, IMM, JMPLD, SKIP, HALT.
- IDLE:
  - If start=1, go to FETCH; otherwise stay in IDLE.
- FETCH:
  - read_en=4, write_en[2]=1 for MEM_WAIT cycles (counter 0..MEM_WAIT-1), then DECODE.
- DECODE:
  - read_en=4, no strobes.
  - Latch opcode and index.
  - Go to the execute path. Every path ends with a single inc_en[0] pulse, then FETCH.
- Opcodes and execute paths:
  - 0 NOP: inc_en[0].
  - 1 LDAC: MEMRD (read_en=4, we AC, MEM_WAIT cycles, memory addressed by DAR), then inc_en[0].
  - 2 STAC: MEMWR (read_en=3, we[5], MEM_WAIT cycles), then inc_en[0].
  - 3 MVACR: read_en=3, we[6+idx], inc_en[0].
  - 4 MVRAC: read_en=8+idx, we AC, inc_en[0].
  - 5 MVACDAR: read_en=3, we[3], inc_en[0].
  - 6 MVDARAC: read_en=2, we AC, inc_en[0].
  - 7..10 ADD/SUB/LSH/RSH:
    - ALU1: alu_op set, no write.
    - ALU2: alu_op held, alu_wr=1, inc_en[0].
  - 11 INCAC: inc_en[1]|inc_en[0].
  - 12 INCDAR: inc_en[2]|inc_en[0].
  - 13 INCR: inc_en[3+idx]|inc_en[0].
  - 14 LDIM: inc_en[0], then IMM (read_en=4, we AC, MEM_WAIT cycles), then inc_en[0].
  - 15 JMP: inc_en[0], then JMPLD (read_en=4, we[1], MEM_WAIT cycles), then FETCH with no extra increment.
  - 16 JMPZ: inc_en[0], then JMPLD if z=1, else SKIP (inc_en[0]) then FETCH.
    - z is sampled in DECODE.
  - 17 JMPNZ: as JMPZ with the condition inverted.
  - 18 HALT: state HALT, read_en=0, no strobes, held until reset.
- Index rules:
  - Register opcodes (3, 4, 13) with idx>=NREG are illegal.
  - Opcodes 19..63 are illegal.
- Illegal opcode: illegal pulses once; execution as NOP. See Optional Feature.
- Invariant: at most one write_en bit is set in any cycle.
- start deasserted after leaving IDLE has no effect.
- reset in any state, including mid-wait, returns to IDLE on the next edge.

Optional Feature:
- Macro CTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode goes from DECODE to HALT. The illegal pulse fires, end_process=1 thereafter, and PC is not incremented.
- Undefined: an illegal opcode pulses illegal and behaves as NOP.

Test Plan:
- Reset, start=1, MEM_WAIT=2, IR=0x0000:
  - FETCH asserts write_en[2] exactly 2 cycles, DECODE 1 cycle, then inc_en[0] pulses once.
  - Return to FETCH on cycle 5.
- IR=0x0203 (MVACR idx 2), NREG=6:
  - read_en=3, write_en=bit8 only, inc_en[0] in the same cycle.
  - IR=0x0903 (idx 9) pulses illegal, no register write.
- IR=0x0007 (ADD):
  - ALU1 alu_op=1, alu_wr=0.
  - ALU2 alu_op=1, alu_wr=1, inc_en[0]=1.
- JMPZ with z=1: inc_en[0], then write_en[1] with read_en=4 for 2 cycles, then FETCH.
- JMPZ with z=0: two separate inc_en[0] pulses, no write_en[1].
- IR=0x0012 (HALT): end_process=1 one cycle after HALT entry and stays high.
- Assert reset mid-MEMRD: IDLE on the next edge, all outputs 0, end_process=0.
